// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM encoding and default timing.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_DONE    = 2'd1,
    ST_HOLD    = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_DOMAINS     = 3;
  localparam int DEF_GAP_CYCLES      = 8;
  localparam int DEF_SOFT_RST_CYCLES = 16;
  localparam int DEF_CNT_WIDTH       = 8;

endpackage

// File: rtl/rst_seq_timer.sv
// Shared interval counter with a registered terminal-count flag.
// The flag reflects (count == i_term) for the count currently held in the register.
module rst_seq_timer #(
  parameter int CNT_WIDTH = 8,
  parameter bit TC_INIT   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_term,
  output logic                 o_tc
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_tc;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear)       w_cnt_nxt = '0;
    else if (i_enable) w_cnt_nxt = r_cnt + 1'b1;
  end

  // Compare against the next count so the flag lines up with the stored count;
  // i_term must already describe the state the counter is entering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_tc  <= TC_INIT;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tc  <= (w_cnt_nxt == i_term);
    end
  end

  assign o_tc = r_tc;

endmodule

// File: rtl/rst_sequencer.sv
// Staged per-domain reset release with software soft-reset replay.
// Domain 0 leaves reset first; all outputs come straight from registers.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SOFT_RST_REQ,
  output logic [NUM_DOMAINS-1:0] SEQ_RST_N,
  output logic                   SEQ_DONE,
  output logic                   SEQ_BUSY
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] GAP_TERM  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SOFT_TERM = CNT_WIDTH'(SOFT_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             r_state, w_state_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_busy;
  logic                   r_req_prev;
  logic                   w_req;
  logic                   w_clear, w_enable, w_tc;
  logic [CNT_WIDTH-1:0]   w_term;

  assign w_req  = SOFT_RST_REQ & ~r_req_prev;
  assign w_term = (w_state_nxt == ST_HOLD) ? SOFT_TERM : GAP_TERM;

  rst_seq_timer #(
    .CNT_WIDTH (CNT_WIDTH),
    .TC_INIT   (GAP_CYCLES == 1)
  ) u_timer (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_term   (w_term),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rst_n_nxt = r_rst_n;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_done;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      ST_RELEASE: begin
        if (w_tc) begin
          for (int i = 0; i < NUM_DOMAINS; i++)
            if (IDX_W'(i) == r_idx) w_rst_n_nxt[i] = 1'b1;
          w_clear = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_enable = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_req) begin
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
          w_clear     = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          w_clear     = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_enable = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: drop every domain and replay from scratch.
        w_rst_n_nxt = '0;
        w_done_nxt  = 1'b0;
        w_idx_nxt   = '0;
        w_clear     = 1'b1;
        w_state_nxt = ST_RELEASE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_RELEASE;
      r_rst_n    <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b1;
      r_req_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_idx      <= w_idx_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= ~w_done_nxt;
      r_req_prev <= SOFT_RST_REQ;
    end
  end

  assign SEQ_RST_N = r_rst_n;
  assign SEQ_DONE  = r_done;
  assign SEQ_BUSY  = r_busy;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default (3,8,16) instance plus a (1,1,1) corner instance.
module tb_rst_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REQ = 1'b0;
  logic [2:0] seq_rst_n;
  logic       seq_done, seq_busy;

  logic       bRST = 1'b0;
  logic       bREQ = 1'b0;
  logic [0:0] b_rst_n;
  logic       b_done, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rst_sequencer #(
    .NUM_DOMAINS(3), .GAP_CYCLES(8), .SOFT_RST_CYCLES(16), .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(REQ),
    .SEQ_RST_N(seq_rst_n), .SEQ_DONE(seq_done), .SEQ_BUSY(seq_busy)
  );

  rst_sequencer #(
    .NUM_DOMAINS(1), .GAP_CYCLES(1), .SOFT_RST_CYCLES(1), .CNT_WIDTH(4)
  ) dut_b (
    .CLK(CLK), .RST(bRST), .SOFT_RST_REQ(bREQ),
    .SEQ_RST_N(b_rst_n), .SEQ_DONE(b_done), .SEQ_BUSY(b_busy)
  );

  // Expected default-config outputs t edges after release starts (t <= 0: nothing released).
  function automatic logic [2:0] exp_bits(input int t);
    logic [2:0] b;
    for (int d = 0; d < 3; d++) b[d] = (t >= (d + 1) * 8);
    return b;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_power_up();
    RST = 1'b0;
    REQ = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (seq_rst_n !== 3'b000) begin
      n_fail++; $display("FAIL reset_rst_n: got %b expected 000", seq_rst_n);
    end
    n_checks++;
    if (seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags: done=%b busy=%b expected done=0 busy=1", seq_done, seq_busy);
    end
    @(negedge CLK) RST = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(k)) begin
        n_fail++; $display("FAIL powerup_rst_n edge %0d: got %b expected %b", k, seq_rst_n, exp_bits(k));
      end
      n_checks++;
      if (seq_done !== (k >= 24) || seq_busy !== (k < 24)) begin
        n_fail++; $display("FAIL powerup_flags edge %0d: done=%b busy=%b expected done=%0d", k, seq_done, seq_busy, (k >= 24));
      end
    end
  endtask

  // Must start in DONE. Optionally pulses the request during the hold (edge E+5).
  task automatic test_soft_reset(input bit pulse_in_hold);
    @(negedge CLK) REQ = 1'b1;
    tick();
    REQ = 1'b0;
    n_checks++;
    if (seq_rst_n !== 3'b000 || seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      n_fail++; $display("FAIL soft_assert: rst_n=%b done=%b busy=%b expected 000/0/1", seq_rst_n, seq_done, seq_busy);
    end
    for (int j = 1; j <= 45; j++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(j - 16)) begin
        n_fail++; $display("FAIL soft_rst_n pulse=%0d E+%0d: got %b expected %b", pulse_in_hold, j, seq_rst_n, exp_bits(j - 16));
      end
      n_checks++;
      if (seq_done !== (j >= 40) || seq_busy !== (j < 40)) begin
        n_fail++; $display("FAIL soft_flags pulse=%0d E+%0d: done=%b busy=%b expected done=%0d", pulse_in_hold, j, seq_done, seq_busy, (j >= 40));
      end
      if (pulse_in_hold && j == 4) REQ = 1'b1;
      if (j == 5) REQ = 1'b0;
    end
  endtask

  task automatic test_ignored_release();
    RST = 1'b0;
    repeat (2) tick();
    @(negedge CLK) RST = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(k)) begin
        n_fail++; $display("FAIL ign_release_rst_n edge %0d: got %b expected %b", k, seq_rst_n, exp_bits(k));
      end
      n_checks++;
      if (seq_done !== (k >= 24)) begin
        n_fail++; $display("FAIL ign_release_done edge %0d: got %b expected %0d", k, seq_done, (k >= 24));
      end
      if (k == 11) REQ = 1'b1;
      if (k == 12) REQ = 1'b0;
    end
  endtask

  task automatic test_held_request();
    @(negedge CLK) REQ = 1'b1;
    tick();
    n_checks++;
    if (seq_rst_n !== 3'b000 || seq_done !== 1'b0) begin
      n_fail++; $display("FAIL held_assert: rst_n=%b done=%b expected 000/0", seq_rst_n, seq_done);
    end
    for (int j = 1; j <= 110; j++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(j - 16)) begin
        n_fail++; $display("FAIL held_rst_n E+%0d: got %b expected %b", j, seq_rst_n, exp_bits(j - 16));
      end
      n_checks++;
      if (seq_done !== (j >= 40)) begin
        n_fail++; $display("FAIL held_done E+%0d: got %b expected %0d", j, seq_done, (j >= 40));
      end
      if (j == 99) REQ = 1'b0;
    end
  endtask

  task automatic test_req_through_reset();
    RST = 1'b0;
    REQ = 1'b1;
    repeat (3) tick();
    @(negedge CLK) RST = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(k) || seq_done !== (k >= 24)) begin
        n_fail++; $display("FAIL req_thru_reset edge %0d: rst_n=%b done=%b expected %b/%0d", k, seq_rst_n, seq_done, exp_bits(k), (k >= 24));
      end
    end
    REQ = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (seq_rst_n !== 3'b111 || seq_done !== 1'b1) begin
      n_fail++; $display("FAIL req_thru_reset_drop: rst_n=%b done=%b expected 111/1", seq_rst_n, seq_done);
    end
  endtask

  task automatic test_async_mid();
    RST = 1'b0;
    repeat (2) tick();
    @(negedge CLK) RST = 1'b1;
    repeat (17) tick();
    n_checks++;
    if (seq_rst_n !== 3'b011) begin
      n_fail++; $display("FAIL async_pre edge 17: got %b expected 011", seq_rst_n);
    end
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (seq_rst_n !== 3'b000 || seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      n_fail++; $display("FAIL async_immediate: rst_n=%b done=%b busy=%b expected 000/0/1", seq_rst_n, seq_done, seq_busy);
    end
    @(negedge CLK) RST = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      n_checks++;
      if (seq_rst_n !== exp_bits(k) || seq_done !== (k >= 24)) begin
        n_fail++; $display("FAIL async_restart edge %0d: rst_n=%b done=%b expected %b/%0d", k, seq_rst_n, seq_done, exp_bits(k), (k >= 24));
      end
    end
  endtask

  task automatic test_boundary();
    bRST = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (b_rst_n !== 1'b0 || b_done !== 1'b0 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL bnd_reset: rst_n=%b done=%b busy=%b expected 0/0/1", b_rst_n, b_done, b_busy);
    end
    @(negedge CLK) bRST = 1'b1;
    tick();
    n_checks++;
    if (b_rst_n !== 1'b1 || b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL bnd_edge1: rst_n=%b done=%b busy=%b expected 1/1/0", b_rst_n, b_done, b_busy);
    end
    @(negedge CLK) bREQ = 1'b1;
    tick();
    bREQ = 1'b0;
    n_checks++;
    if (b_rst_n !== 1'b0 || b_done !== 1'b0) begin
      n_fail++; $display("FAIL bnd_soft_E: rst_n=%b done=%b expected 0/0", b_rst_n, b_done);
    end
    tick();
    n_checks++;
    if (b_rst_n !== 1'b0 || b_done !== 1'b0) begin
      n_fail++; $display("FAIL bnd_soft_E1: rst_n=%b done=%b expected 0/0", b_rst_n, b_done);
    end
    tick();
    n_checks++;
    if (b_rst_n !== 1'b1 || b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL bnd_soft_E2: rst_n=%b done=%b busy=%b expected 1/1/0", b_rst_n, b_done, b_busy);
    end
  endtask

  initial begin
    test_power_up();
    test_soft_reset(1'b0);
    test_soft_reset(1'b1);
    test_ignored_release();
    test_held_request();
    test_req_through_reset();
    test_async_mid();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
